// File: rtl/recepcion_serial.sv
// recepcion_serial: MSB-first serial-to-parallel receiver with frame sync,
// sticky framing/overrun flags and a first-word-fall-through output FIFO.
//
// Ports:
//   clk        in   system clock, serial inputs sampled on the rising edge
//   reset      in   synchronous, active-high reset
//   DataIn     in   serial data, MSB first
//   SyncIn     in   high in the bit period carrying a frame's MSB
//   rdEn       in   pop the FIFO head (ignored when empty)
//   clrErr     in   clear the sticky error flags
//   dataOut    out  FIFO head word, 0 when empty
//   empty      out  FIFO holds no words
//   full       out  FIFO holds DEPTH words
//   count      out  number of words held
//   overrun    out  sticky: a completed word was dropped
//   frameError out  sticky: a sync arrived mid-frame
module recepcion_serial #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       DataIn,
    input  logic                       SyncIn,
    input  logic                       rdEn,
    input  logic                       clrErr,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    output logic                       frameError
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] shReg_q, shReg_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             frameErr_q, frameErr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic wordDone;
    logic frameEvt;
    logic ovEvt;
    logic push;
    logic pop;
    logic emptyInt;
    logic fullInt;

    assign emptyInt = (count_q == '0);
    assign fullInt  = (count_q == (AW+1)'(DEPTH));

    // Deserializer. A sync in SHIFT restarts the frame with the current
    // bit as MSB, even on the edge that would otherwise complete a word.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shReg_d  = shReg_q;
        wordDone = 1'b0;
        frameEvt = 1'b0;
        case (state_q)
            IDLE: begin
                if (SyncIn) begin
                    shReg_d  = {{(WIDTH-1){1'b0}}, DataIn};
                    bitCnt_d = CW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (SyncIn) begin
                    frameEvt = 1'b1;
                    shReg_d  = {{(WIDTH-1){1'b0}}, DataIn};
                    bitCnt_d = CW'(1);
                end else begin
                    shReg_d = {shReg_q[WIDTH-2:0], DataIn};
                    if (bitCnt_q == CW'(WIDTH-1)) begin
                        wordDone = 1'b1;
                        bitCnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end
        endcase
    end

    // When full, a same-cycle read frees the head slot, which is exactly
    // where the write pointer sits, so the new word can still be stored.
    always_comb begin
        pop   = rdEn && !emptyInt;
        push  = wordDone && (!fullInt || rdEn);
        ovEvt = wordDone && fullInt && !rdEn;

        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // Error events take priority over a simultaneous clear.
        overrun_d  = ovEvt    || (overrun_q  && !clrErr);
        frameErr_d = frameEvt || (frameErr_q && !clrErr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shReg_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shReg_q    <= shReg_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Storage needs no reset: dataOut is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wrPtr_q] <= shReg_d;
        end
    end

    assign dataOut    = emptyInt ? '0 : mem_q[rdPtr_q];
    assign empty      = emptyInt;
    assign full       = fullInt;
    assign count      = count_q;
    assign overrun    = overrun_q;
    assign frameError = frameErr_q;

endmodule

// File: doc/recepcion_serial.md
# recepcion_serial

Serial-to-parallel receiver, the counterpart to the team's 16-bit DAC serializer. Captures an MSB-first serial stream that changes on the falling edge of `clk`, rebuilds 16-bit words using a one-bit frame-sync marker, and buffers them in a small first-word-fall-through FIFO for the game logic. It also flags framing and overrun errors. It sits between the external ADC/serial link pins and the sample-processing logic.

## Interface
- `WIDTH`, default 16: bits per frame.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.
- `clk`  in  1  system clock. Single clock domain. Serial data and sync are sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `DataIn`  in  1  serial data, MSB first, stable around the rising edge.
- `SyncIn`  in  1  high in the bit period that carries a frame's MSB.
- `rdEn`  in  1  pop the FIFO head. Ignored when `empty`.
- `clrErr`  in  1  clear the sticky error flags.
- `dataOut`  out  WIDTH  FIFO head word. Forced to 0 when `empty`.
- `empty`  out  1  FIFO holds 0 words.
- `full`  out  1  FIFO holds DEPTH words.
- `count`  out  log2(DEPTH)+1  number of words held.
- `overrun`  out  1  sticky: a completed word was dropped.
- `frameError`  out  1  sticky: a sync arrived mid-frame.

## Operation
- Two-state FSM: IDLE and SHIFT. A bit counter `bitCnt` runs from 0 to WIDTH-1.
- **IDLE**
  - With `SyncIn`=1: shift `DataIn` in as the MSB, set `bitCnt`=1, go to SHIFT.
  - Otherwise `DataIn` is ignored.
- **SHIFT**, each rising edge:
  - Shift `DataIn` into the LSB side of the shift register and increment `bitCnt`.
  - The edge that captures bit WIDTH-1 (the LSB) completes the word. The full word, including that bit, is pushed to the FIFO in the same edge.
  - After completion, go to IDLE. A `SyncIn` on the next edge starts the next frame, so back-to-back frames lose no bits.
- **Sync mid-frame**
  - Applies when `SyncIn`=1 in SHIFT with `bitCnt` from 1 to WIDTH-1, including the LSB edge.
  - The partial word is discarded and nothing is pushed.
  - `frameError` is set.
  - The current bit is taken as the MSB of a new frame: `bitCnt`=1, stay in SHIFT.
- **FIFO push**
  - Happens when a word completes and (`!full`, or `full` and `rdEn` in the same cycle).
  - A word that completes while full without `rdEn` is dropped and `overrun` is set. FIFO contents are unchanged.
- **FIFO pop**
  - `rdEn` && `!empty` advances the read pointer.
  - Simultaneous push and pop leaves `count` unchanged.
- Pointers wrap modulo DEPTH. `count` is tracked explicitly, and `full`/`empty` decode from it.
- **clrErr**: clears both flags on the next edge. If an error event happens in the same cycle, the event wins and the flag stays set.
- **Reset** (also valid mid-frame):
  - State IDLE, `bitCnt`=0, shift register 0, pointers 0.
  - `count`=0, `empty`=1, `full`=0, `dataOut`=0, `overrun`=0, `frameError`=0.
  - The partial frame is discarded.

## Timing
- Edge E0 samples the MSB, with `SyncIn`=1. Edge E(WIDTH-1) samples the LSB and writes the FIFO.
- From the start of the frame (E0) to valid `dataOut`: WIDTH edges. After E(WIDTH-1) the word appears on `dataOut` if the FIFO was empty, `empty` falls, and `count` increments.
- Pop latency is one edge. After the edge with `rdEn`, `dataOut` shows the next word, or 0 if the FIFO is now empty.
- All outputs are registered or decoded from registers. There are no combinational paths from input to output.
- Maximum sustained rate: one word per WIDTH cycles.

## Test plan
- **Single frame.** Reset, then send 0xA5C3 MSB-first with `SyncIn` on the first bit.
  - Required: `empty`=0 after edge 16, `dataOut`=0xA5C3, `count`=1.
  - Then pulse `rdEn`: `empty`=1, `dataOut`=0.
- **Back-to-back frames with overrun.** 5 frames 0x0001..0x0005, no reads, DEPTH=4.
  - Required: `full`=1, `count`=4, `overrun`=1.
  - Popping returns 0x0001..0x0004 in order; 0x0005 is lost.
- **Sync mid-frame.** Assert `SyncIn` at bit 7 of a frame, then send 16 bits of 0x1234.
  - Required: `frameError`=1, only 0x1234 is stored, `count`=1.
  - `clrErr` then clears the flag.
- **Read/write collision when full.** With the FIFO full (0x0001..0x0004), complete 0x0009 on the same edge as `rdEn`.
  - Required: `count` stays 4, `overrun`=0.
  - Subsequent reads return 0x0002, 0x0003, 0x0004, 0x0009.
- **Underflow guard.** Pulse `rdEn` while empty.
  - Required: `count` stays 0 and the pointers do not move. A following frame 0xBEEF reads back correctly.
- **Reset mid-frame.** Assert `reset` at bit 9 with 2 words stored.
  - Required: all outputs return to their reset values.
  - The next synced frame 0x0F0F is received intact with `frameError`=0.
